// File: rtl/imem_loader_if.sv
// Stream and memory-write bundle for the instruction memory loader.
// The master side supplies the byte stream and sinks the memory write port.
// The slave side is the loader itself.
interface imem_loader_if #(
  parameter int ADDR_W = 7
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Byte-stream program loader for the instruction memory.
// Parses SYNC, LEN_LO, LEN_HI, payload and XOR checksum, writes the payload
// one byte per accepted transfer, and keeps the core held until a frame
// arrives intact.
module imem_loader #(
  parameter int         ADDR_W    = 7,
  parameter int         MEM_BYTES = 128,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic            clk,
  input  logic            rst,
  imem_loader_if.slave    bus,
  output logic            core_hold,
  output logic            load_done,
  output logic            load_err,
  output logic [ADDR_W:0] bytes_written
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [7:0]        len_lo;
  logic [7:0]        len_hi;
  logic [7:0]        xor_sum;
  logic [CNT_W-1:0]  count;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              core_hold_q;
  logic              load_err_q;

  logic              ready_state;
  logic              xfer;
  logic [15:0]       len_full;
  logic [15:0]       len_latched;
  logic [15:0]       count_plus1;

  logic              start_frame;
  logic              latch_lo;
  logic              latch_hi;
  logic              write_byte;
  logic              enter_err;
  logic              enter_done;

  // The loader takes bytes in every parsing state; the DONE/ERR cycles and
  // reset itself are the only times the stream is back-pressured.
  assign ready_state = (state == S_IDLE)   || (state == S_LEN_LO) ||
                       (state == S_LEN_HI) || (state == S_DATA)   ||
                       (state == S_CHK);
  assign xfer        = bus.in_valid && ready_state;

  // Length as it would be if the current byte were LEN_HI, the length
  // already latched, and the payload count after the current byte.
  assign len_full    = {bus.in_data, len_lo};
  assign len_latched = {len_hi, len_lo};
  assign count_plus1 = 16'(count) + 16'd1;

  // State register; reset aborts any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Frame parser: next state plus one-cycle strobes for the datapath.
  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    latch_lo    = 1'b0;
    latch_hi    = 1'b0;
    write_byte  = 1'b0;
    enter_err   = 1'b0;
    enter_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (xfer && (bus.in_data == SYNC_BYTE)) begin
          start_frame = 1'b1;
          state_next  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          latch_lo   = 1'b1;
          state_next = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          latch_hi = 1'b1;
          if (len_full > 16'(MEM_BYTES)) begin
            enter_err  = 1'b1;
            state_next = S_ERR;
          end else if (len_full == 16'd0) begin
            state_next = S_CHK;
          end else begin
            state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          write_byte = 1'b1;
          if (count_plus1 == len_latched) begin
            state_next = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (xfer) begin
          if (bus.in_data == xor_sum) begin
            enter_done = 1'b1;
            state_next = S_DONE;
          end else begin
            enter_err  = 1'b1;
            state_next = S_ERR;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      S_ERR: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Length latches; they only matter between LEN_HI and the last payload byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_lo <= 8'h00;
      len_hi <= 8'h00;
    end else begin
      if (latch_lo) begin
        len_lo <= bus.in_data;
      end
      if (latch_hi) begin
        len_hi <= bus.in_data;
      end
    end
  end

  // Payload path: registered write port, running XOR and byte count.
  // The count doubles as the write address; the length check in LEN_HI
  // guarantees it never exceeds MEM_BYTES, so the address never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      count       <= '0;
      xor_sum     <= 8'h00;
    end else begin
      mem_we_q <= write_byte;
      if (start_frame) begin
        count   <= '0;
        xor_sum <= 8'h00;
      end else if (write_byte) begin
        mem_addr_q  <= count[ADDR_W-1:0];
        mem_wdata_q <= bus.in_data;
        count       <= count + CNT_W'(1);
        xor_sum     <= xor_sum ^ bus.in_data;
      end
    end
  end

  // Core hold and sticky error: both re-armed by a new SYNC, hold released
  // only when a frame checks out, error raised by a bad length or checksum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_hold_q <= 1'b1;
      load_err_q  <= 1'b0;
    end else begin
      if (start_frame) begin
        core_hold_q <= 1'b1;
        load_err_q  <= 1'b0;
      end else if (enter_done) begin
        core_hold_q <= 1'b0;
      end else if (enter_err) begin
        load_err_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready   = ready_state && !rst;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign core_hold      = core_hold_q;
  assign load_err       = load_err_q;
  assign load_done      = (state == S_DONE);
  assign bytes_written  = count;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed frames with a cycle-stamped event
// scoreboard built from the frame format, checked every cycle.
module tb_imem_loader;

  localparam int ADDR_W = 7;
  localparam int K_NONE  = 0;
  localparam int K_SYNC  = 1;
  localparam int K_WRITE = 2;
  localparam int K_DONE  = 3;
  localparam int K_ERR   = 4;

  typedef struct {
    int cyc;
    int kind;
    int addr;
    int data;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            core_hold;
  logic            load_done;
  logic            load_err;
  logic [ADDR_W:0] bytes_written;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(
    .ADDR_W    (ADDR_W),
    .MEM_BYTES (128),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .core_hold     (core_hold),
    .load_done     (load_done),
    .load_err      (load_err),
    .bytes_written (bytes_written)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  int wr_seen      = 0;
  int done_seen    = 0;
  int last_wr_addr = -1;

  bit armed  = 1'b0;
  bit m_hold = 1'b1;
  bit m_err  = 1'b0;
  int m_bw   = 0;
  int m_addr = 0;
  int m_data = 0;

  ev_t        evq[$];
  logic [7:0] frame_q[$];

  bit  we_exp;
  bit  done_exp;
  bit  skip_hold;
  bit  skip_err;
  int  e_addr;
  int  e_data;
  ev_t ev;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) wait_neg();
  endtask

  // Per-cycle compare against the event scoreboard.
  always @(negedge clk) begin
    if (armed) begin
      we_exp    = 1'b0;
      done_exp  = 1'b0;
      skip_hold = 1'b0;
      skip_err  = 1'b0;
      e_addr    = 0;
      e_data    = 0;
      while (evq.size() > 0 && evq[0].cyc <= cyc) begin
        ev = evq.pop_front();
        if (ev.cyc != cyc) check_output("event_slip", ev.cyc, cyc);
        case (ev.kind)
          K_SYNC:  begin m_hold = 1'b1; m_err = 1'b0; m_bw = 0; end
          K_WRITE: begin we_exp = 1'b1; e_addr = ev.addr; e_data = ev.data; m_bw = ev.addr + 1; end
          K_DONE:  begin done_exp = 1'b1; m_hold = 1'b0; skip_hold = 1'b1; end
          K_ERR:   begin m_err = 1'b1; skip_err = 1'b1; end
          default: ;
        endcase
      end
      if (rst) begin
        evq.delete();
        m_hold = 1'b1;
        m_err  = 1'b0;
        m_bw   = 0;
        m_addr = 0;
        m_data = 0;
        check_output("rst_in_ready",  int'(bus.in_ready),  0);
        check_output("rst_mem_we",    int'(bus.mem_we),    0);
        check_output("rst_mem_addr",  int'(bus.mem_addr),  0);
        check_output("rst_mem_wdata", int'(bus.mem_wdata), 0);
        check_output("rst_core_hold", int'(core_hold),     1);
        check_output("rst_load_done", int'(load_done),     0);
        check_output("rst_load_err",  int'(load_err),      0);
        check_output("rst_bytes",     int'(bytes_written), 0);
      end else begin
        check_output("mem_we", int'(bus.mem_we), int'(we_exp));
        if (bus.mem_we) begin
          wr_seen++;
          last_wr_addr = int'(bus.mem_addr);
        end
        if (we_exp) begin
          m_addr = e_addr;
          m_data = e_data;
        end
        check_output("mem_addr",      int'(bus.mem_addr),  m_addr);
        check_output("mem_wdata",     int'(bus.mem_wdata), m_data);
        check_output("bytes_written", int'(bytes_written), m_bw);
        check_output("load_done",     int'(load_done),     int'(done_exp));
        if (!skip_hold) check_output("core_hold", int'(core_hold), int'(m_hold));
        if (!skip_err)  check_output("load_err",  int'(load_err),  int'(m_err));
        check_output("done_err_excl", int'(load_done && load_err), 0);
        if (load_done) done_seen++;
      end
    end
  end

  // Present one byte, optionally after a random stall, and record what its
  // acceptance must cause on the following cycle.
  task automatic apply_stimulus(input logic [7:0] b, input bit stall,
                                input int kind, input int addr);
    int  guard;
    int  n;
    ev_t e;
    if (stall) begin
      n = int'($urandom_range(0, 2));
      repeat (n) begin
        bus.in_valid = 1'b0;
        wait_neg();
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    guard = 0;
    while (!bus.in_ready && guard < 20) begin
      wait_neg();
      guard++;
    end
    if (!bus.in_ready) begin
      check_output("in_ready_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    if (kind != K_NONE) begin
      e.cyc  = cyc + 1;
      e.kind = kind;
      e.addr = addr;
      e.data = int'(b);
      evq.push_back(e);
    end
    wait_neg();
  endtask

  // Send frame_q (or its first nsend bytes) and derive the expected effect
  // of each byte from the frame layout.
  task automatic send_frame(input bit stall, input int nsend);
    int         n;
    int         total;
    int         kind;
    int         addr;
    logic [7:0] x;
    n = int'({frame_q[2], frame_q[1]});
    x = 8'h00;
    if (n <= 128) begin
      for (int i = 0; i < n; i++) x = x ^ frame_q[3 + i];
    end
    total = (nsend < 0) ? frame_q.size() : nsend;
    for (int i = 0; i < total; i++) begin
      kind = K_NONE;
      addr = 0;
      if (i == 0) begin
        kind = K_SYNC;
      end else if (i == 2 && n > 128) begin
        kind = K_ERR;
      end else if (i >= 3 && i < 3 + n) begin
        kind = K_WRITE;
        addr = i - 3;
      end else if (i == 3 + n) begin
        kind = (frame_q[i] == x) ? K_DONE : K_ERR;
      end
      apply_stimulus(frame_q[i], stall, kind, addr);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic basic_frame(input logic [7:0] chk);
    frame_q = '{8'hA5, 8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, chk};
  endtask

  initial begin
    int         w0;
    int         d0;
    logic [7:0] chk;
    logic [7:0] d;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #1 rst = 1'b1;
    armed = 1'b1;
    idle(2);
    check_output("init_in_ready",  int'(bus.in_ready), 0);
    check_output("init_core_hold", int'(core_hold),    1);
    rst = 1'b0;
    idle(2);
    check_output("idle_in_ready", int'(bus.in_ready), 1);

    // Good four-byte frame, no stalls
    w0 = wr_seen; d0 = done_seen;
    basic_frame(8'h13);
    send_frame(1'b0, -1);
    idle(3);
    check_output("s2_writes",    wr_seen - w0,        4);
    check_output("s2_done",      done_seen - d0,      1);
    check_output("s2_bytes",     int'(bytes_written), 4);
    check_output("s2_core_hold", int'(core_hold),     0);
    check_output("s2_load_err",  int'(load_err),      0);
    check_output("s2_last_addr", last_wr_addr,        3);

    // Asynchronous reset pulse between clock edges
    #2 rst = 1'b1;
    #1;
    check_output("arst_in_ready",  int'(bus.in_ready),  0);
    check_output("arst_core_hold", int'(core_hold),     1);
    check_output("arst_bytes",     int'(bytes_written), 0);
    check_output("arst_mem_addr",  int'(bus.mem_addr),  0);
    wait_neg();
    rst = 1'b0;
    idle(1);

    // Bad checksum: payload still written, error raised, core stays held
    w0 = wr_seen; d0 = done_seen;
    basic_frame(8'h12);
    send_frame(1'b0, -1);
    idle(3);
    check_output("s3_writes",    wr_seen - w0,    4);
    check_output("s3_done",      done_seen - d0,  0);
    check_output("s3_load_err",  int'(load_err),  1);
    check_output("s3_core_hold", int'(core_hold), 1);

    // Oversize length: rejected before any write
    w0 = wr_seen;
    frame_q = '{8'hA5, 8'h81, 8'h00};
    send_frame(1'b0, -1);
    idle(3);
    check_output("s4_writes",   wr_seen - w0,        0);
    check_output("s4_load_err", int'(load_err),      1);
    check_output("s4_bytes",    int'(bytes_written), 0);

    // Full-capacity frame, including a SYNC value inside the payload
    w0 = wr_seen; d0 = done_seen;
    frame_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'h80);
    frame_q.push_back(8'h00);
    chk = 8'h00;
    for (int i = 0; i < 128; i++) begin
      d = (i == 10) ? 8'hA5 : 8'(i * 3 + 1);
      frame_q.push_back(d);
      chk = chk ^ d;
    end
    frame_q.push_back(chk);
    send_frame(1'b0, -1);
    idle(3);
    check_output("s4b_writes",    wr_seen - w0,        128);
    check_output("s4b_last_addr", last_wr_addr,        127);
    check_output("s4b_done",      done_seen - d0,      1);
    check_output("s4b_load_err",  int'(load_err),      0);
    check_output("s4b_bytes",     int'(bytes_written), 128);

    // Garbage before an empty frame
    w0 = wr_seen; d0 = done_seen;
    apply_stimulus(8'h00, 1'b0, K_NONE, 0);
    apply_stimulus(8'hFF, 1'b0, K_NONE, 0);
    apply_stimulus(8'h5A, 1'b0, K_NONE, 0);
    bus.in_valid = 1'b0;
    frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame(1'b0, -1);
    idle(3);
    check_output("s5_writes",    wr_seen - w0,    0);
    check_output("s5_done",      done_seen - d0,  1);
    check_output("s5_core_hold", int'(core_hold), 0);

    // SYNC values as payload bytes are data
    w0 = wr_seen; d0 = done_seen;
    frame_q = '{8'hA5, 8'h02, 8'h00, 8'hA5, 8'hA5, 8'h00};
    send_frame(1'b0, -1);
    idle(3);
    check_output("sp_writes", wr_seen - w0,   2);
    check_output("sp_done",   done_seen - d0, 1);

    // Stalled good frame
    w0 = wr_seen; d0 = done_seen;
    basic_frame(8'h13);
    send_frame(1'b1, -1);
    idle(3);
    check_output("s6_writes", wr_seen - w0,   4);
    check_output("s6_done",   done_seen - d0, 1);

    // Stalled frame aborted by reset after the second payload byte
    w0 = wr_seen;
    basic_frame(8'h13);
    send_frame(1'b1, 5);
    check_output("s6r_pending", evq.size(),   0);
    check_output("s6r_writes",  wr_seen - w0, 2);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    check_output("s6r_in_ready",  int'(bus.in_ready), 1);
    check_output("s6r_core_hold", int'(core_hold),    1);
    d0 = done_seen;
    basic_frame(8'h13);
    send_frame(1'b0, -1);
    idle(3);
    check_output("s6r_reload_done", done_seen - d0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Overall time bound
  initial begin
    #300000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
